// File: rtl/sar_pkg.sv
// Shared types and helpers for the SAR conversion sequencer.
package sar_pkg;

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} sar_state_t;

    localparam int MAX_CH = 32;

    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Lowest set bit of mask at or above index 'from'; -1 when there is none.
    function automatic int next_channel(input logic [MAX_CH-1:0] mask, input int from);
        int idx;
        idx = -1;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i] && i >= from) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/sar_bit_engine.sv
// Binary-search core: bit index, accumulator and trial-code generation.
module sar_bit_engine #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             step,
    input  logic             cmp,
    output logic [WIDTH-1:0] trial,
    output logic [WIDTH-1:0] acc,
    output logic             last
);

    localparam int KW = $clog2(WIDTH);

    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] acc_q;

    // Each step resolves the current bit and moves down; index parks at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            k_q   <= KW'(WIDTH - 1);
        end else if (clear) begin
            acc_q <= '0;
            k_q   <= KW'(WIDTH - 1);
        end else if (step) begin
            acc_q[k_q] <= cmp;
            if (k_q != '0) k_q <= k_q - 1'b1;
        end
    end

    assign trial = acc_q | (WIDTH'(1) << k_q);
    assign acc   = acc_q;
    assign last  = (k_q == '0);

endmodule

// File: rtl/sar_seq_ctrl.sv
// Multi-channel SAR sequencer: sample phase, bit-serial conversion, tagged results.
module sar_seq_ctrl import sar_pkg::*; #(
    parameter int WIDTH         = 6,
    parameter int CHANNELS      = 4,
    parameter int SAMPLE_CYCLES = 2,
    localparam int CH_W         = ch_width(CHANNELS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                cont_i,
    input  logic                abort_i,
    input  logic [CHANNELS-1:0] ch_mask_i,
    input  logic                cmp_i,
    output logic                sample_o,
    output logic [CH_W-1:0]     ch_o,
    output logic [WIDTH-1:0]    dac_o,
    output logic [WIDTH-1:0]    result_o,
    output logic [CH_W-1:0]     result_ch_o,
    output logic                valid_o,
    output logic                eoc_o,
    output logic                busy_o
);

    localparam int SC_W = $clog2(SAMPLE_CYCLES + 1);

    sar_state_t          state;
    logic [CHANNELS-1:0] mask_q;
    logic [CH_W-1:0]     ch_q;
    logic [SC_W-1:0]     samp_cnt;
    logic [WIDTH-1:0]    result_q;
    logic [CH_W-1:0]     result_ch_q;
    logic                valid_q;
    logic                eoc_q;
    logic [WIDTH-1:0]    eng_trial;
    logic [WIDTH-1:0]    eng_acc;
    logic                eng_last;
    int                  first_idx;
    int                  nxt_idx;

    sar_bit_engine #(.WIDTH(WIDTH)) u_engine (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clear (state == SAMPLE),
        .step  (state == CONVERT),
        .cmp   (cmp_i),
        .trial (eng_trial),
        .acc   (eng_acc),
        .last  (eng_last)
    );

    always_comb begin
        first_idx = next_channel(MAX_CH'(ch_mask_i), 0);
        nxt_idx   = next_channel(MAX_CH'(mask_q), int'(ch_q) + 1);
    end

    // Result and pulses are registered on the edge entering DONE so they are visible during DONE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            mask_q      <= '0;
            ch_q        <= '0;
            samp_cnt    <= '0;
            result_q    <= '0;
            result_ch_q <= '0;
            valid_q     <= 1'b0;
            eoc_q       <= 1'b0;
        end else begin
            valid_q  <= 1'b0;
            eoc_q    <= 1'b0;
            samp_cnt <= '0;
            if (abort_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i && ch_mask_i != '0) begin
                            mask_q <= ch_mask_i;
                            ch_q   <= CH_W'(first_idx);
                            state  <= SAMPLE;
                        end
                    end
                    SAMPLE: begin
                        if (samp_cnt == SC_W'(SAMPLE_CYCLES - 1)) state <= CONVERT;
                        else samp_cnt <= samp_cnt + 1'b1;
                    end
                    CONVERT: begin
                        if (eng_last) begin
                            result_q    <= {eng_acc[WIDTH-1:1], cmp_i};
                            result_ch_q <= ch_q;
                            valid_q     <= 1'b1;
                            eoc_q       <= (nxt_idx < 0);
                            state       <= DONE;
                        end
                    end
                    DONE: begin
                        if (nxt_idx >= 0) begin
                            ch_q  <= CH_W'(nxt_idx);
                            state <= SAMPLE;
                        end else if (cont_i && ch_mask_i != '0) begin
                            mask_q <= ch_mask_i;
                            ch_q   <= CH_W'(first_idx);
                            state  <= SAMPLE;
                        end else begin
                            if (cont_i) mask_q <= ch_mask_i;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        dac_o = '0;
        case (state)
            CONVERT: dac_o = eng_trial;
            DONE:    dac_o = eng_acc;
            default: dac_o = '0;
        endcase
    end

    assign sample_o    = (state == SAMPLE);
    assign busy_o      = (state != IDLE);
    assign ch_o        = ch_q;
    assign result_o    = result_q;
    assign result_ch_o = result_ch_q;
    assign valid_o     = valid_q;
    assign eoc_o       = eoc_q;

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// Self-checking bench: fixed code vectors, hand-written corner sequences and randomized scans.
module tb_sar_seq_ctrl;

    logic       clk_i;
    logic       rst_ni;
    logic       start_i;
    logic       cont_i;
    logic       abort_i;
    logic [3:0] ch_mask_i;
    logic       cmp_i;
    logic       sample_o;
    logic [1:0] ch_o;
    logic [5:0] dac_o;
    logic [5:0] result_o;
    logic [1:0] result_ch_o;
    logic       valid_o;
    logic       eoc_o;
    logic       busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int vin [4];
    int dac_q [$];
    int last_exp_result;

    typedef struct packed {
        logic [5:0]      vin;
        logic [5:0]      result;
        logic [5:0][5:0] dac;
    } vec_t;

    vec_t vecs [5];

    sar_seq_ctrl #(.WIDTH(6), .CHANNELS(4), .SAMPLE_CYCLES(2)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .cont_i      (cont_i),
        .abort_i     (abort_i),
        .ch_mask_i   (ch_mask_i),
        .cmp_i       (cmp_i),
        .sample_o    (sample_o),
        .ch_o        (ch_o),
        .dac_o       (dac_o),
        .result_o    (result_o),
        .result_ch_o (result_ch_o),
        .valid_o     (valid_o),
        .eoc_o       (eoc_o),
        .busy_o      (busy_o)
    );

    // Analog front end: comparator reports vin of the selected channel against the DAC code.
    assign cmp_i = (vin[ch_o] >= int'(dac_o));

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_sample"}, int'(sample_o), 0);
        check_output({tag, "_ch"}, int'(ch_o), 0);
        check_output({tag, "_dac"}, int'(dac_o), 0);
        check_output({tag, "_result"}, int'(result_o), 0);
        check_output({tag, "_result_ch"}, int'(result_ch_o), 0);
        check_output({tag, "_valid"}, int'(valid_o), 0);
        check_output({tag, "_eoc"}, int'(eoc_o), 0);
        check_output({tag, "_busy"}, int'(busy_o), 0);
    endtask

    task automatic apply_stimulus(input logic [3:0] mask, input logic cont);
        @(negedge clk_i);
        ch_mask_i = mask;
        cont_i    = cont;
        start_i   = 1'b1;
        @(negedge clk_i);
        start_i   = 1'b0;
    endtask

    // Single-shot scan: each enabled channel ascending yields one result equal to its vin, 9 cycles apart.
    task automatic run_scan(input string tag, input logic [3:0] mask);
        int exp_ch [$];
        int cyc;
        int got;
        int last_cyc;
        for (int c = 0; c < 4; c++) if (mask[c]) exp_ch.push_back(c);
        dac_q.delete();
        apply_stimulus(mask, 1'b0);
        check_output({tag, "_first_sample"}, int'(sample_o), 1);
        cyc = 1;
        got = 0;
        last_cyc = 0;
        while (got < exp_ch.size() && cyc < 200) begin
            if (busy_o && !sample_o && !valid_o) dac_q.push_back(int'(dac_o));
            if (valid_o) begin
                check_output({tag, "_tag"}, int'(result_ch_o), exp_ch[got]);
                check_output({tag, "_result"}, int'(result_o), vin[exp_ch[got]]);
                check_output({tag, "_eoc"}, int'(eoc_o), (got == exp_ch.size() - 1) ? 1 : 0);
                check_output({tag, "_latency"}, cyc - last_cyc, 9);
                check_output({tag, "_done_dac"}, int'(dac_o), vin[exp_ch[got]]);
                last_exp_result = vin[exp_ch[got]];
                last_cyc = cyc;
                got++;
            end
            if (got < exp_ch.size()) begin
                @(negedge clk_i);
                cyc++;
            end
        end
        check_output({tag, "_pulse_count"}, got, exp_ch.size());
        @(negedge clk_i);
        check_output({tag, "_busy_after"}, int'(busy_o), 0);
        check_output({tag, "_valid_after"}, int'(valid_o), 0);
    endtask

    task automatic set_vec(input int idx, input int v, input int r,
                           input int d0, input int d1, input int d2,
                           input int d3, input int d4, input int d5);
        vecs[idx].vin    = 6'(v);
        vecs[idx].result = 6'(r);
        vecs[idx].dac    = {6'(d0), 6'(d1), 6'(d2), 6'(d3), 6'(d4), 6'(d5)};
    endtask

    initial begin
        int cyc;
        int got;
        int last_cyc;
        int seen;
        int prev;
        logic [3:0] m;

        set_vec(0, 37, 37, 32, 48, 40, 36, 38, 37);
        set_vec(1,  0,  0, 32, 16,  8,  4,  2,  1);
        set_vec(2, 63, 63, 32, 48, 56, 60, 62, 63);
        set_vec(3, 21, 21, 32, 16, 24, 20, 22, 21);
        set_vec(4, 42, 42, 32, 48, 40, 44, 42, 43);

        rst_ni    = 1'b0;
        start_i   = 1'b0;
        cont_i    = 1'b0;
        abort_i   = 1'b0;
        ch_mask_i = 4'b0;
        for (int i = 0; i < 4; i++) vin[i] = 0;
        repeat (2) @(negedge clk_i);
        check_all_zero("reset");
        rst_ni = 1'b1;

        for (int i = 0; i < 5; i++) begin
            vin[0] = int'(vecs[i].vin);
            run_scan("tbl", 4'b0001);
            check_output("tbl_dac_count", dac_q.size(), 6);
            for (int j = 0; j < 6 && j < dac_q.size(); j++)
                check_output("tbl_dac_seq", dac_q[j], int'(vecs[i].dac[5-j]));
            check_output("tbl_final", int'(result_o), int'(vecs[i].result));
        end

        vin[0] = 10; vin[1] = 20; vin[2] = 30; vin[3] = 40;
        run_scan("multi", 4'b1010);

        // Continuous single-channel run; mask cleared mid-way through the fourth conversion.
        vin[0] = 45;
        apply_stimulus(4'b0001, 1'b1);
        cyc = 1; got = 0; last_cyc = 0;
        while (got < 4 && cyc < 200) begin
            if (valid_o) begin
                check_output("cont_result", int'(result_o), 45);
                check_output("cont_tag", int'(result_ch_o), 0);
                check_output("cont_eoc", int'(eoc_o), 1);
                check_output("cont_period", cyc - last_cyc, 9);
                last_cyc = cyc;
                got++;
            end
            if (got == 3 && cyc == last_cyc + 3) ch_mask_i = 4'b0000;
            if (got < 4) begin
                @(negedge clk_i);
                cyc++;
            end
        end
        check_output("cont_pulses", got, 4);
        @(negedge clk_i);
        check_output("cont_stop_busy", int'(busy_o), 0);
        cont_i = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk_i);
            if (valid_o || busy_o) seen++;
        end
        check_output("cont_quiet", seen, 0);
        last_exp_result = 45;

        // Abort during the third CONVERT cycle.
        vin[0] = 12;
        prev = last_exp_result;
        apply_stimulus(4'b0001, 1'b0);
        repeat (4) @(negedge clk_i);
        check_output("abort_in_convert", int'(busy_o && !sample_o), 1);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        check_output("abort_busy", int'(busy_o), 0);
        check_output("abort_dac", int'(dac_o), 0);
        check_output("abort_sample", int'(sample_o), 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk_i);
            if (valid_o || eoc_o || busy_o) seen++;
        end
        check_output("abort_no_valid", seen, 0);
        check_output("abort_result_kept", int'(result_o), prev);

        // Start with an all-zero mask must not leave IDLE.
        @(negedge clk_i);
        ch_mask_i = 4'b0000;
        start_i   = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk_i);
            if (busy_o || valid_o || sample_o) seen++;
        end
        start_i = 1'b0;
        check_output("zero_mask_idle", seen, 0);

        // Asynchronous reset in the middle of SAMPLE, away from any clock edge.
        vin[2] = 30;
        apply_stimulus(4'b0100, 1'b0);
        check_output("pre_rst_ch", int'(ch_o), 2);
        #2 rst_ni = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_scan("post_rst", 4'b0100);

        // Randomized scans against the channel-order / vin model.
        for (int it = 0; it < 16; it++) begin
            m = 4'($urandom_range(0, 15));
            for (int c = 0; c < 4; c++) vin[c] = int'($urandom_range(0, 63));
            if (m == 4'b0000) begin
                apply_stimulus(m, 1'b0);
                check_output("rand_zero_mask", int'(busy_o), 0);
            end else begin
                run_scan("rand", m);
            end
        end

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
